// File: rtl/pixel_fifo_if.sv
// Handshake bundle between a pixel producer/consumer and pixel_fifo.
// Error flags exist only when PIXEL_FIFO_ERR_EN is defined.
interface pixel_fifo_if #(
    parameter int N          = 8,
    parameter int DEPTH_LOG2 = 4
);
    logic [N-1:0]        d;
    logic                we;
    logic                re;
    logic [N-1:0]        q;
    logic                valid;
    logic                full;
    logic                almost_full;
    logic                empty;
    logic [DEPTH_LOG2:0] count;
`ifdef PIXEL_FIFO_ERR_EN
    logic                overflow;
    logic                underflow;
`endif

    modport master (
        output d, we, re,
        input  q, valid, full, almost_full, empty, count
`ifdef PIXEL_FIFO_ERR_EN
        , input overflow, underflow
`endif
    );

    modport slave (
        input  d, we, re,
        output q, valid, full, almost_full, empty, count
`ifdef PIXEL_FIFO_ERR_EN
        , output overflow, underflow
`endif
    );
endinterface

// File: rtl/pixel_fifo.sv
// Synchronous pixel FIFO with registered read and registered status flags.
// Define PIXEL_FIFO_ERR_EN to add sticky overflow/underflow outputs.
module pixel_fifo #(
    parameter int N          = 8,
    parameter int DEPTH_LOG2 = 4,
    parameter int AF_LEVEL   = (2 ** DEPTH_LOG2) - 2
) (
    input logic         clk,
    input logic         rst,
    pixel_fifo_if.slave bus
);
    localparam int PTR_W = DEPTH_LOG2;
    localparam int CNT_W = DEPTH_LOG2 + 1;
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_CNT    = CNT_W'(AF_LEVEL);

    logic [N-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_next;
    logic [N-1:0]     q_r;
    logic             valid_r;
    logic             full_r;
    logic             almost_full_r;
    logic             empty_r;
    logic             re_ok;
    logic             we_ok;

    // Empty is judged before the write, so a read on an empty FIFO never
    // sees a word written in the same cycle; a full FIFO accepts a write
    // only when a read frees a slot in the same cycle.
    always_comb begin
        re_ok = bus.re && !empty_r;
        we_ok = bus.we && (!full_r || re_ok);
    end

    always_comb begin
        count_next = count_r;
        case ({we_ok, re_ok})
            2'b10:   count_next = count_r + CNT_W'(1);
            2'b01:   count_next = count_r - CNT_W'(1);
            default: count_next = count_r;
        endcase
    end

    always_ff @(posedge clk) begin
        if (we_ok && !rst) begin
            mem[wptr] <= bus.d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr          <= '0;
            rptr          <= '0;
            count_r       <= '0;
            q_r           <= '0;
            valid_r       <= 1'b0;
            full_r        <= 1'b0;
            almost_full_r <= (AF_CNT == '0);
            empty_r       <= 1'b1;
        end else begin
            if (we_ok) begin
                wptr <= wptr + PTR_W'(1);
            end
            if (re_ok) begin
                rptr <= rptr + PTR_W'(1);
                q_r  <= mem[rptr];
            end
            valid_r       <= re_ok;
            count_r       <= count_next;
            full_r        <= (count_next == DEPTH_CNT);
            almost_full_r <= (count_next >= AF_CNT);
            empty_r       <= (count_next == '0);
        end
    end

`ifdef PIXEL_FIFO_ERR_EN
    logic overflow_r;
    logic underflow_r;

    // Sticky until reset so a late-arriving monitor still sees the event.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (bus.we && !we_ok) begin
                overflow_r <= 1'b1;
            end
            if (bus.re && !re_ok) begin
                underflow_r <= 1'b1;
            end
        end
    end

    always_comb begin
        bus.overflow  = overflow_r;
        bus.underflow = underflow_r;
    end
`endif

    always_comb begin
        bus.q           = q_r;
        bus.valid       = valid_r;
        bus.full        = full_r;
        bus.almost_full = almost_full_r;
        bus.empty       = empty_r;
        bus.count       = count_r;
    end
endmodule

// File: tb/tb_pixel_fifo.sv
// Directed, table-driven bench for pixel_fifo at N=8, DEPTH_LOG2=2.
// Checks overflow/underflow too when PIXEL_FIFO_ERR_EN is defined.
module tb_pixel_fifo;
    logic clk;
    logic rst;
    int   compared;
    int   mismatched;

    pixel_fifo_if #(.N(8), .DEPTH_LOG2(2)) bus ();

    pixel_fifo #(.N(8), .DEPTH_LOG2(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       we;
        logic       re;
        logic [7:0] d;
        logic [7:0] q;
        logic       valid;
        logic [2:0] count;
        logic       full;
        logic       af;
        logic       empty;
        logic       ovf;
        logic       unf;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic w, logic rd, logic [7:0] d,
                                logic [7:0] q, logic v, logic [2:0] c,
                                logic f, logic af, logic e, logic ovf, logic unf);
        vec_t x;
        x.rst = r; x.we = w; x.re = rd; x.d = d;
        x.q = q; x.valid = v; x.count = c;
        x.full = f; x.af = af; x.empty = e; x.ovf = ovf; x.unf = unf;
        return x;
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drive on the falling edge, let the rising edge act, sample 1 time unit later.
    task automatic apply_stimulus(input logic r, input logic w, input logic rd,
                                  input logic [7:0] d);
        @(negedge clk);
        rst    = r;
        bus.we = w;
        bus.re = rd;
        bus.d  = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int max_count;
        compared   = 0;
        mismatched = 0;
        rst    = 1'b1;
        bus.we = 1'b0;
        bus.re = 1'b0;
        bus.d  = '0;

        //            rst we re d      q      v  cnt f  af e  ovf unf
        vecs.push_back(mk(1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 8'h11, 8'h00, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 8'h22, 8'h00, 0, 2, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 8'h33, 8'h00, 0, 3, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 8'h44, 8'h00, 0, 4, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 8'h55, 8'h00, 0, 4, 1, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 8'h00, 8'h11, 1, 3, 0, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 8'h00, 8'h22, 1, 2, 0, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 8'h00, 8'h22, 0, 2, 0, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 8'h00, 8'h33, 1, 1, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 8'h00, 8'h44, 1, 0, 0, 0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 1, 8'h00, 8'h44, 0, 0, 0, 0, 1, 1, 1));
        vecs.push_back(mk(0, 1, 1, 8'hA5, 8'h44, 0, 1, 0, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 1, 8'h00, 8'hA5, 1, 0, 0, 0, 1, 1, 1));
        vecs.push_back(mk(0, 1, 0, 8'h01, 8'hA5, 0, 1, 0, 0, 0, 1, 1));
        vecs.push_back(mk(0, 1, 0, 8'h02, 8'hA5, 0, 2, 0, 1, 0, 1, 1));
        vecs.push_back(mk(0, 1, 0, 8'h03, 8'hA5, 0, 3, 0, 1, 0, 1, 1));
        vecs.push_back(mk(0, 1, 0, 8'h04, 8'hA5, 0, 4, 1, 1, 0, 1, 1));
        vecs.push_back(mk(0, 1, 1, 8'h66, 8'h01, 1, 4, 1, 1, 0, 1, 1));
        vecs.push_back(mk(0, 0, 1, 8'h00, 8'h02, 1, 3, 0, 1, 0, 1, 1));
        vecs.push_back(mk(0, 0, 1, 8'h00, 8'h03, 1, 2, 0, 1, 0, 1, 1));
        vecs.push_back(mk(0, 0, 1, 8'h00, 8'h04, 1, 1, 0, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 1, 8'h00, 8'h66, 1, 0, 0, 0, 1, 1, 1));
        vecs.push_back(mk(0, 1, 0, 8'h07, 8'h66, 0, 1, 0, 0, 0, 1, 1));
        vecs.push_back(mk(0, 1, 0, 8'h08, 8'h66, 0, 2, 0, 1, 0, 1, 1));
        vecs.push_back(mk(0, 1, 0, 8'h09, 8'h66, 0, 3, 0, 1, 0, 1, 1));
        vecs.push_back(mk(1, 1, 1, 8'hFF, 8'h00, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 8'h00, 8'h00, 0, 0, 0, 0, 1, 0, 1));

        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(vecs[i].rst, vecs[i].we, vecs[i].re, vecs[i].d);
            check_output($sformatf("v%0d.q", i), 32'(bus.q), 32'(vecs[i].q));
            check_output($sformatf("v%0d.valid", i), 32'(bus.valid), 32'(vecs[i].valid));
            check_output($sformatf("v%0d.count", i), 32'(bus.count), 32'(vecs[i].count));
            check_output($sformatf("v%0d.full", i), 32'(bus.full), 32'(vecs[i].full));
            check_output($sformatf("v%0d.almost_full", i), 32'(bus.almost_full), 32'(vecs[i].af));
            check_output($sformatf("v%0d.empty", i), 32'(bus.empty), 32'(vecs[i].empty));
`ifdef PIXEL_FIFO_ERR_EN
            check_output($sformatf("v%0d.overflow", i), 32'(bus.overflow), 32'(vecs[i].ovf));
            check_output($sformatf("v%0d.underflow", i), 32'(bus.underflow), 32'(vecs[i].unf));
`endif
        end

        // Wrap-around: write k while reading k-1, pointers wrap past depth 4 twice.
        max_count = 0;
        for (int k = 0; k <= 10; k++) begin
            apply_stimulus(1'b0, (k < 10), (k >= 1), 8'(k));
            if (int'(bus.count) > max_count) max_count = int'(bus.count);
            check_output($sformatf("wrap%0d.valid", k), 32'(bus.valid), 32'(k >= 1));
            if (k >= 1) begin
                check_output($sformatf("wrap%0d.q", k), 32'(bus.q), 32'(k - 1));
            end
            check_output($sformatf("wrap%0d.count", k), 32'(bus.count), 32'((k < 10) ? 1 : 0));
        end
        check_output("wrap.max_count", 32'(max_count), 32'(1));

        apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00);
        check_output("wrap.idle_valid", 32'(bus.valid), 32'(0));
        check_output("wrap.idle_q_hold", 32'(bus.q), 32'(9));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
